// File: rtl/sifive_insight_tl_pkg.sv
// Shared TileLink D-channel types and beat arithmetic for the Insight D-user capture monitor.
package sifive_insight_tl_pkg;

  typedef enum logic [2:0] {
    TL_ACCESS_ACK      = 3'd0,
    TL_ACCESS_ACK_DATA = 3'd1,
    TL_HINT_ACK        = 3'd2,
    TL_GRANT           = 3'd4,
    TL_GRANT_DATA      = 3'd5,
    TL_RELEASE_ACK     = 3'd6
  } tl_d_opcode_e;

  // Burst tracker state; exported on the capture block's debug port.
  typedef enum logic {
    B_IDLE  = 1'b0,
    B_BURST = 1'b1
  } burst_state_e;

  localparam int DEF_USER_W   = 4;
  localparam int DEF_SOURCE_W = 4;
  localparam int DEF_BEAT_W   = 8;

  // Record layout at the default widths.
  typedef struct packed {
    logic [2:0]              opcode;
    logic [DEF_SOURCE_W-1:0] source;
    logic [DEF_USER_W-1:0]   user;
    logic [DEF_BEAT_W-1:0]   beats;
    logic                    denied;
    logic                    corrupt;
  } d_user_rec_t;

  // Only data-carrying responses larger than one bus beat span several beats.
  function automatic int unsigned beats_for(input logic [2:0] opcode,
                                            input int unsigned size,
                                            input int unsigned beat_lg2);
    if ((opcode == TL_ACCESS_ACK_DATA || opcode == TL_GRANT_DATA) && size > beat_lg2)
      return 32'd1 << (size - beat_lg2);
    return 32'd1;
  endfunction

endpackage

// File: rtl/sifive_insight_sync_fifo.sv
// Single-clock FIFO with occupancy count; head entry reads as zero while empty.
module sifive_insight_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [W-1:0]     push_data,
  input  logic             pop,
  output logic [W-1:0]     pop_data,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  assign full     = (level == LVL_W'(DEPTH));
  assign empty    = (level == '0);
  assign pop_data = empty ? '0 : mem[rd_ptr];

  // Storage carries no reset; empty gating keeps the output clean.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/sifive_insight_tl_d_user_capture.sv
// Passive TileLink D-channel monitor collapsing each message into one buffered record.
// Optional per-record timestamp enabled by defining INSIGHT_D_USER_TIMESTAMP_EN.
module sifive_insight_tl_d_user_capture
  import sifive_insight_tl_pkg::*;
#(
  parameter int USER_W   = 4,
  parameter int SOURCE_W = 4,
  parameter int SIZE_W   = 3,
  parameter int BEAT_LG2 = 2,
  parameter int BEAT_W   = 8,
  parameter int DEPTH    = 8,
  parameter int CNT_W    = 16,
  parameter int TS_W     = 32,
  parameter int LVL_W    = $clog2(DEPTH) + 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic                d_valid,
  input  logic                d_ready,
  input  logic [2:0]          d_opcode,
  input  logic [SOURCE_W-1:0] d_source,
  input  logic [SIZE_W-1:0]   d_size,
  input  logic [USER_W-1:0]   d_user,
  input  logic                d_denied,
  input  logic                d_corrupt,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2:0]          out_opcode,
  output logic [SOURCE_W-1:0] out_source,
  output logic [USER_W-1:0]   out_user,
  output logic [BEAT_W-1:0]   out_beats,
  output logic                out_denied,
  output logic                out_corrupt,
`ifdef INSIGHT_D_USER_TIMESTAMP_EN
  output logic [TS_W-1:0]     out_ts,
`endif
  output logic [LVL_W-1:0]    level,
  output logic [CNT_W-1:0]    drop_count,
  output burst_state_e        fsm_state
);

  typedef struct packed {
    logic [2:0]          opcode;
    logic [SOURCE_W-1:0] source;
    logic [USER_W-1:0]   user;
    logic [BEAT_W-1:0]   beats;
    logic                denied;
    logic                corrupt;
`ifdef INSIGHT_D_USER_TIMESTAMP_EN
    logic [TS_W-1:0]     ts;
`endif
  } rec_t;

  // Handshake: a D beat fires on d_valid&d_ready (observed only); a record
  // leaves the FIFO on out_valid&out_ready and out_* hold while stalled.
  logic fire;
  logic pop;
  logic push;
  logic push_req;
  logic drop;
  logic full;
  logic empty;
  logic last;
  logic [BEAT_W-1:0] total;
  rec_t cur_rec;
  rec_t head_rec;
  logic cur_en;

  // Fields latched from the first beat of a multi-beat message.
  logic [BEAT_W-1:0]   remaining;
  logic [2:0]          h_opcode;
  logic [SOURCE_W-1:0] h_source;
  logic [USER_W-1:0]   h_user;
  logic [BEAT_W-1:0]   h_beats;
  logic                h_denied;
  logic                h_corrupt;
  logic                h_en;

`ifdef INSIGHT_D_USER_TIMESTAMP_EN
  logic [TS_W-1:0] ts_cnt;
  logic [TS_W-1:0] h_ts;

  always_ff @(posedge clock) begin
    if (reset) ts_cnt <= '0;
    else       ts_cnt <= ts_cnt + 1'b1;
  end
`endif

  assign fire  = d_valid & d_ready;
  assign total = BEAT_W'(beats_for(d_opcode, 32'(d_size), BEAT_LG2));

  always_comb begin
    cur_rec = '0;
    cur_en  = 1'b0;
    last    = 1'b0;
    if (fsm_state == B_IDLE) begin
      cur_rec.opcode  = d_opcode;
      cur_rec.source  = d_source;
      cur_rec.user    = d_user;
      cur_rec.beats   = total;
      cur_rec.denied  = d_denied;
      cur_rec.corrupt = d_corrupt;
`ifdef INSIGHT_D_USER_TIMESTAMP_EN
      cur_rec.ts      = ts_cnt;
`endif
      cur_en          = enable;
      last            = (total == BEAT_W'(1));
    end else begin
      cur_rec.opcode  = h_opcode;
      cur_rec.source  = h_source;
      cur_rec.user    = h_user;
      cur_rec.beats   = h_beats;
      cur_rec.denied  = h_denied | d_denied;
      cur_rec.corrupt = h_corrupt | d_corrupt;
`ifdef INSIGHT_D_USER_TIMESTAMP_EN
      cur_rec.ts      = h_ts;
`endif
      cur_en          = h_en;
      last            = (remaining == BEAT_W'(1));
    end
  end

  // A full FIFO still accepts the record when the head leaves the same cycle.
  assign pop      = out_valid & out_ready;
  assign push_req = fire & last & cur_en;
  assign push     = push_req & (~full | pop);
  assign drop     = push_req & full & ~pop;

  always_ff @(posedge clock) begin
    if (reset) begin
      fsm_state <= B_IDLE;
      remaining <= '0;
      h_opcode  <= '0;
      h_source  <= '0;
      h_user    <= '0;
      h_beats   <= '0;
      h_denied  <= 1'b0;
      h_corrupt <= 1'b0;
      h_en      <= 1'b0;
`ifdef INSIGHT_D_USER_TIMESTAMP_EN
      h_ts      <= '0;
`endif
    end else if (fire) begin
      case (fsm_state)
        B_IDLE: begin
          if (total != BEAT_W'(1)) begin
            fsm_state <= B_BURST;
            remaining <= total - 1'b1;
            h_opcode  <= d_opcode;
            h_source  <= d_source;
            h_user    <= d_user;
            h_beats   <= total;
            h_denied  <= d_denied;
            h_corrupt <= d_corrupt;
            h_en      <= enable;
`ifdef INSIGHT_D_USER_TIMESTAMP_EN
            h_ts      <= ts_cnt;
`endif
          end
        end
        B_BURST: begin
          remaining <= remaining - 1'b1;
          h_denied  <= h_denied | d_denied;
          h_corrupt <= h_corrupt | d_corrupt;
          if (remaining == BEAT_W'(1)) fsm_state <= B_IDLE;
        end
        default: fsm_state <= B_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset)                          drop_count <= '0;
    else if (drop && drop_count != '1)  drop_count <= drop_count + 1'b1;
  end

  sifive_insight_sync_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(rec_t)),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (cur_rec),
    .pop       (pop),
    .pop_data  (head_rec),
    .full      (full),
    .empty     (empty),
    .level     (level)
  );

  assign out_valid   = ~empty;
  assign out_opcode  = head_rec.opcode;
  assign out_source  = head_rec.source;
  assign out_user    = head_rec.user;
  assign out_beats   = head_rec.beats;
  assign out_denied  = head_rec.denied;
  assign out_corrupt = head_rec.corrupt;
`ifdef INSIGHT_D_USER_TIMESTAMP_EN
  assign out_ts      = head_rec.ts;
`endif

endmodule

// File: tb/tb_sifive_insight_tl_d_user_capture.sv
// Directed bench for the D-user capture monitor: vector table plus corner sequences.
module tb_sifive_insight_tl_d_user_capture;
  import sifive_insight_tl_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic        d_valid;
  logic        d_ready;
  logic [2:0]  d_opcode;
  logic [3:0]  d_source;
  logic [2:0]  d_size;
  logic [3:0]  d_user;
  logic        d_denied;
  logic        d_corrupt;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_opcode;
  logic [3:0]  out_source;
  logic [3:0]  out_user;
  logic [7:0]  out_beats;
  logic        out_denied;
  logic        out_corrupt;
  logic [3:0]  level;
  logic [15:0] drop_count;
  burst_state_e fsm_state;
`ifdef INSIGHT_D_USER_TIMESTAMP_EN
  logic [31:0] out_ts;
  logic [31:0] ts_model;
  logic [31:0] exp_ts;
`endif

  int n_vec  = 0;
  int n_fail = 0;

  sifive_insight_tl_d_user_capture dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .d_valid     (d_valid),
    .d_ready     (d_ready),
    .d_opcode    (d_opcode),
    .d_source    (d_source),
    .d_size      (d_size),
    .d_user      (d_user),
    .d_denied    (d_denied),
    .d_corrupt   (d_corrupt),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_opcode  (out_opcode),
    .out_source  (out_source),
    .out_user    (out_user),
    .out_beats   (out_beats),
    .out_denied  (out_denied),
    .out_corrupt (out_corrupt),
`ifdef INSIGHT_D_USER_TIMESTAMP_EN
    .out_ts      (out_ts),
`endif
    .level       (level),
    .drop_count  (drop_count),
    .fsm_state   (fsm_state)
  );

  // Clock and reset
  always #5 clock = ~clock;

`ifdef INSIGHT_D_USER_TIMESTAMP_EN
  always @(posedge clock) begin
    if (reset) ts_model <= '0;
    else       ts_model <= ts_model + 1;
  end
`endif

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    d_valid   = 1'b0;
    d_ready   = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Driver: one firing beat, called at a negedge, returns at the next negedge.
  task automatic beat(input logic [2:0] op, input logic [3:0] src, input logic [2:0] sz,
                      input logic [3:0] usr, input logic den, input logic cor);
    d_valid   = 1'b1;
    d_ready   = 1'b1;
    d_opcode  = op;
    d_source  = src;
    d_size    = sz;
    d_user    = usr;
    d_denied  = den;
    d_corrupt = cor;
    tick();
    d_valid = 1'b0;
    d_ready = 1'b0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0] opcode;
    logic [3:0] source;
    logic [2:0] size;
    logic [3:0] user;
    logic [7:0] den_mask;
    logic [7:0] cor_mask;
    int         beats;
    logic       exp_denied;
    logic       exp_corrupt;
  } vec_t;

  vec_t vt [8];

  initial begin
    vt[0] = '{3'd0, 4'h3, 3'd2, 4'hA, 8'h00, 8'h00, 1, 1'b0, 1'b0};
    vt[1] = '{3'd1, 4'h1, 3'd4, 4'h5, 8'h00, 8'h04, 4, 1'b0, 1'b1};
    vt[2] = '{3'd1, 4'h6, 3'd2, 4'h9, 8'h00, 8'h00, 1, 1'b0, 1'b0};
    vt[3] = '{3'd5, 4'hF, 3'd3, 4'h3, 8'h02, 8'h00, 2, 1'b1, 1'b0};
    vt[4] = '{3'd4, 4'h2, 3'd5, 4'h7, 8'h00, 8'h01, 1, 1'b0, 1'b1};
    vt[5] = '{3'd1, 4'h8, 3'd5, 4'hC, 8'h80, 8'h01, 8, 1'b1, 1'b1};
    vt[6] = '{3'd2, 4'h4, 3'd6, 4'h1, 8'h00, 8'h00, 1, 1'b0, 1'b0};
    vt[7] = '{3'd6, 4'hE, 3'd0, 4'h0, 8'h01, 8'h00, 1, 1'b1, 1'b0};

    enable    = 1'b1;
    d_opcode  = '0;
    d_source  = '0;
    d_size    = '0;
    d_user    = '0;
    d_denied  = 1'b0;
    d_corrupt = 1'b0;
    @(negedge clock);
    do_reset();

    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_drop", 32'(drop_count), 32'd0);
    check("rst_beats", 32'(out_beats), 32'd0);
    check("rst_source", 32'(out_source), 32'd0);
    check("rst_state", 32'(fsm_state), 32'(B_IDLE));

    // Vector table: one message each, with a stalled cycle after beat 1 of bursts.
    for (int i = 0; i < 8; i++) begin
      for (int b = 0; b < vt[i].beats; b++) begin
        beat(vt[i].opcode, vt[i].source, vt[i].size, (b == 0) ? vt[i].user : ~vt[i].user,
             vt[i].den_mask[b], vt[i].cor_mask[b]);
        if (b == 0 && vt[i].beats > 1) begin
          d_valid = 1'b1; d_ready = 1'b0; d_denied = 1'b1; d_corrupt = 1'b1;
          d_opcode = 3'd0; d_source = ~vt[i].source;
          tick();
          d_valid = 1'b0;
          d_denied = 1'b0; d_corrupt = 1'b0;
          check("stall_no_rec", 32'(out_valid), 32'd0);
        end
        if (b < vt[i].beats - 1) check("early_rec", 32'(out_valid), 32'd0);
      end
      check("vec_valid", 32'(out_valid), 32'd1);
      check("vec_opcode", 32'(out_opcode), 32'(vt[i].opcode));
      check("vec_source", 32'(out_source), 32'(vt[i].source));
      check("vec_user", 32'(out_user), 32'(vt[i].user));
      check("vec_beats", 32'(out_beats), 32'(vt[i].beats));
      check("vec_denied", 32'(out_denied), 32'(vt[i].exp_denied));
      check("vec_corrupt", 32'(out_corrupt), 32'(vt[i].exp_corrupt));
      check("vec_level", 32'(level), 32'd1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("vec_popped", 32'(level), 32'd0);
    end

    // Overflow with consumer stalled, then in-order drain.
    do_reset();
    for (int i = 0; i < 10; i++) beat(3'd0, 4'(i), 3'd2, 4'(i), 1'b0, 1'b0);
    check("ovf_level", 32'(level), 32'd8);
    check("ovf_drop", 32'(drop_count), 32'd2);
    for (int i = 0; i < 8; i++) begin
      check("drain_valid", 32'(out_valid), 32'd1);
      check("drain_source", 32'(out_source), 32'(i));
      check("drain_user", 32'(out_user), 32'(i));
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
    check("drain_level", 32'(level), 32'd0);
    check("drain_valid_end", 32'(out_valid), 32'd0);

    // Full FIFO: completion coinciding with a pop, then drop counter saturation.
    do_reset();
    for (int i = 0; i < 8; i++) beat(3'd0, 4'(i), 3'd2, 4'h0, 1'b0, 1'b0);
    out_ready = 1'b1;
    beat(3'd0, 4'h9, 3'd2, 4'h0, 1'b0, 1'b0);
    out_ready = 1'b0;
    check("fullpop_level", 32'(level), 32'd8);
    check("fullpop_drop", 32'(drop_count), 32'd0);
    check("fullpop_head", 32'(out_source), 32'd1);
    d_valid = 1'b1; d_ready = 1'b1; d_opcode = 3'd0; d_size = 3'd2;
    repeat (65534) tick();
    check("sat_fffe", 32'(drop_count), 32'hFFFE);
    tick();
    check("sat_ffff", 32'(drop_count), 32'hFFFF);
    tick();
    check("sat_hold", 32'(drop_count), 32'hFFFF);
    d_valid = 1'b0; d_ready = 1'b0;
    check("sat_level", 32'(level), 32'd8);

    // enable is only sampled on the first beat.
    do_reset();
    enable = 1'b0;
    beat(3'd5, 4'h4, 3'd3, 4'h1, 1'b0, 1'b0);
    enable = 1'b1;
    beat(3'd5, 4'h4, 3'd3, 4'h1, 1'b0, 1'b0);
    check("en_off_level", 32'(level), 32'd0);
    check("en_off_valid", 32'(out_valid), 32'd0);
    beat(3'd0, 4'h7, 3'd2, 4'h2, 1'b0, 1'b0);
    check("en_next_level", 32'(level), 32'd1);
    check("en_next_source", 32'(out_source), 32'd7);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    beat(3'd5, 4'hB, 3'd3, 4'h6, 1'b0, 1'b0);
    enable = 1'b0;
    beat(3'd5, 4'hB, 3'd3, 4'h6, 1'b0, 1'b0);
    enable = 1'b1;
    check("en_mid_level", 32'(level), 32'd1);
    check("en_mid_beats", 32'(out_beats), 32'd2);
    check("en_mid_source", 32'(out_source), 32'hB);

    // Reset in the middle of a burst.
    do_reset();
    beat(3'd1, 4'h5, 3'd4, 4'h3, 1'b0, 1'b0);
    beat(3'd1, 4'h5, 3'd4, 4'h3, 1'b0, 1'b0);
    check("mid_state", 32'(fsm_state), 32'(B_BURST));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mrst_level", 32'(level), 32'd0);
    check("mrst_valid", 32'(out_valid), 32'd0);
    check("mrst_state", 32'(fsm_state), 32'(B_IDLE));
    check("mrst_drop", 32'(drop_count), 32'd0);
    tick();
`ifdef INSIGHT_D_USER_TIMESTAMP_EN
    exp_ts = ts_model;
`endif
    beat(3'd0, 4'h2, 3'd2, 4'hC, 1'b0, 1'b0);
    check("post_valid", 32'(out_valid), 32'd1);
    check("post_beats", 32'(out_beats), 32'd1);
    check("post_source", 32'(out_source), 32'd2);
    check("post_user", 32'(out_user), 32'hC);
`ifdef INSIGHT_D_USER_TIMESTAMP_EN
    check("post_ts", out_ts, exp_ts);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
